// File: rtl/comm_controller_v3_if.sv
// Host-link bundle for comm_controller_v3: JTAG-UART word FIFOs plus the request bus.
// master = controller side, slave = FIFO/bus environment side.
interface comm_controller_v3_if #(
   parameter int unsigned ADDR_W = 27,
   parameter int unsigned DEV_W  = 3
);
   logic              rx_empty_i;
   logic [31:0]       rx_data_i;
   logic              rx_read_o;
   logic              tx_full_i;
   logic              tx_write_o;
   logic [31:0]       tx_data_o;
   logic              ready_i;
   logic              done_i;
   logic              valid_i;
   logic [31:0]       data_i;
   logic              req_o;
   logic              req_block_o;
   logic              rw_o;
   logic [DEV_W-1:0]  reqdev_o;
   logic [ADDR_W-1:0] add_o;
   logic [31:0]       data_o;
   logic              clear_o;
   logic              exception_o;

   modport master (
      input  rx_empty_i, rx_data_i, tx_full_i, ready_i, done_i, valid_i, data_i,
      output rx_read_o, tx_write_o, tx_data_o, req_o, req_block_o, rw_o, reqdev_o,
             add_o, data_o, clear_o, exception_o
   );

   modport slave (
      output rx_empty_i, rx_data_i, tx_full_i, ready_i, done_i, valid_i, data_i,
      input  rx_read_o, tx_write_o, tx_data_o, req_o, req_block_o, rw_o, reqdev_o,
             add_o, data_o, clear_o, exception_o
   );
endinterface

// File: rtl/comm_controller_v3.sv
// Host-link command sequencer: decodes packets from the rx word FIFO into single/block
// bus transfers, answers on the tx FIFO, and checks a per-packet XOR checksum.
module comm_controller_v3 #(
   parameter int unsigned ADDR_W       = 27,
   parameter int unsigned DEV_W        = 3,
   parameter int unsigned BURST_LEN    = 16,
   parameter int unsigned PURGE_CYCLES = 20000,
   parameter logic [31:0] KEY_SYNC     = 32'h4A78B9F2,
   parameter logic [31:0] XOR_SYNC     = 32'hCD0031F7
) (
   input  logic                 clock_i,
   input  logic                 resetn_i,
   comm_controller_v3_if.master bus
);

   localparam int unsigned IDX_W = $clog2(BURST_LEN);
   localparam int unsigned PTR_W = IDX_W + 1;
   localparam int unsigned CNT_W = $clog2(PURGE_CYCLES + 1);

   localparam logic [PTR_W-1:0]  PTR_FULL   = PTR_W'(BURST_LEN);
   localparam logic [15:0]       N_BURST    = 16'(BURST_LEN);
   localparam logic [ADDR_W-1:0] ADD_WORD   = ADDR_W'(4);
   localparam logic [ADDR_W-1:0] ADD_BURST  = ADDR_W'(4 * BURST_LEN);
   localparam logic [CNT_W-1:0]  CNT_PURGE  = CNT_W'(PURGE_CYCLES);

   localparam logic [4:0] S_PURGE    = 5'd0;
   localparam logic [4:0] S_SYNC     = 5'd1;
   localparam logic [4:0] S_IDLE     = 5'd2;
   localparam logic [4:0] S_CMD      = 5'd3;
   localparam logic [4:0] S_CFG_REQ  = 5'd4;
   localparam logic [4:0] S_CFG_WAIT = 5'd5;
   localparam logic [4:0] S_ADDR     = 5'd6;
   localparam logic [4:0] S_RD_REQ   = 5'd7;
   localparam logic [4:0] S_RD_WAIT  = 5'd8;
   localparam logic [4:0] S_RD_PUSH  = 5'd9;
   localparam logic [4:0] S_WR_POP   = 5'd10;
   localparam logic [4:0] S_WR_REQ   = 5'd11;
   localparam logic [4:0] S_WR_WAIT  = 5'd12;
   localparam logic [4:0] S_BR_REQ   = 5'd13;
   localparam logic [4:0] S_BR_XFER  = 5'd14;
   localparam logic [4:0] S_BW_FILL  = 5'd15;
   localparam logic [4:0] S_BW_REQ   = 5'd16;
   localparam logic [4:0] S_BW_XFER  = 5'd17;
   localparam logic [4:0] S_CSUM_TX  = 5'd18;
   localparam logic [4:0] S_CSUM_RX  = 5'd19;
   localparam logic [4:0] S_ACK      = 5'd20;
   localparam logic [4:0] S_ERR      = 5'd21;

   logic [4:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [1:0]        op_q, op_d;
   logic [DEV_W-1:0]  dev_q, dev_d;
   logic              blk_q, blk_d;
   logic [15:0]       n_q, n_d;
   logic [31:0]       csum_q, csum_d;
   logic [31:0]       rd_q, rd_d;
   logic [PTR_W-1:0]  wp_q, wp_d;
   logic [PTR_W-1:0]  rp_q, rp_d;
   logic              done_seen_q, done_seen_d;
   logic [2:0]        err_q, err_d;
   logic [31:0]       buf_q [BURST_LEN];
   logic [31:0]       buf_d [BURST_LEN];

   logic              req_q, req_d;
   logic              req_block_q, req_block_d;
   logic              rw_q, rw_d;
   logic [DEV_W-1:0]  reqdev_q, reqdev_d;
   logic [ADDR_W-1:0] add_q, add_d;
   logic [31:0]       data_q, data_d;
   logic              clear_q, clear_d;
   logic              exc_q, exc_d;

   logic              rx_read, tx_write;
   logic [31:0]       tx_data, rx_word;
   logic              can_pop, can_push;
   logic [PTR_W-1:0]  rp_nxt;

   assign rx_word  = bus.rx_data_i;
   assign can_pop  = !bus.rx_empty_i;
   assign can_push = !bus.tx_full_i;
   assign rp_nxt   = rp_q + 1'b1;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      op_d        = op_q;
      dev_d       = dev_q;
      blk_d       = blk_q;
      n_d         = n_q;
      csum_d      = csum_q;
      rd_d        = rd_q;
      wp_d        = wp_q;
      rp_d        = rp_q;
      done_seen_d = done_seen_q;
      err_d       = err_q;
      buf_d       = buf_q;
      req_d       = 1'b0;
      req_block_d = req_block_q;
      rw_d        = rw_q;
      reqdev_d    = reqdev_q;
      add_d       = add_q;
      data_d      = data_q;
      clear_d     = 1'b0;
      exc_d       = exc_q;
      rx_read     = 1'b0;
      tx_write    = 1'b0;
      tx_data     = '0;

      case (state_q)
         S_PURGE: begin
            if (can_pop) begin
               rx_read = 1'b1;
               cnt_d   = CNT_PURGE;
            end else if (cnt_q == '0) begin
               state_d = S_SYNC;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_SYNC: begin
            if (can_pop && can_push) begin
               rx_read = 1'b1;
               if (rx_word == KEY_SYNC) begin
                  state_d = S_IDLE;
               end else begin
                  tx_write = 1'b1;
                  tx_data  = rx_word ^ XOR_SYNC;
               end
            end
         end
         S_IDLE: begin
            if (can_pop) begin
               rx_read = 1'b1;
               if (rx_word != '0) begin
                  err_d   = 3'd1;
                  state_d = S_ERR;
               end else begin
                  state_d = S_CMD;
               end
            end
         end
         S_CMD: begin
            if (can_pop) begin
               rx_read = 1'b1;
               op_d    = rx_word[31:30];
               dev_d   = DEV_W'(rx_word[29:27]);
               blk_d   = rx_word[26];
               n_d     = rx_word[15:0];
               csum_d  = '0;
               case (rx_word[31:30])
                  2'b11: begin
                     cnt_d   = CNT_PURGE;
                     state_d = S_PURGE;
                  end
                  2'b10: state_d = S_CFG_REQ;
                  default: begin
                     if (rx_word[15:0] == '0 || (rx_word[26] && rx_word[IDX_W-1:0] != '0)) begin
                        err_d   = 3'd2;
                        state_d = S_ERR;
                     end else begin
                        state_d = S_ADDR;
                     end
                  end
               endcase
            end
         end
         S_CFG_REQ: begin
            if (bus.ready_i) begin
               req_d    = 1'b1;
               rw_d     = 1'b1;
               reqdev_d = dev_q;
               data_d   = {16'h0000, n_q};
               state_d  = S_CFG_WAIT;
            end
         end
         S_CFG_WAIT: begin
            if (bus.done_i) begin
               clear_d = 1'b1;
               state_d = S_ACK;
            end
         end
         S_ADDR: begin
            if (can_pop) begin
               rx_read = 1'b1;
               add_d   = {rx_word[ADDR_W-1:2], 2'b00};
               wp_d    = '0;
               rp_d    = '0;
               if (blk_q && rx_word[IDX_W+1:0] != '0) begin
                  err_d   = 3'd4;
                  state_d = S_ERR;
               end else begin
                  case ({op_q[0], blk_q})
                     2'b00:   state_d = S_RD_REQ;
                     2'b01:   state_d = S_BR_REQ;
                     2'b10:   state_d = S_WR_POP;
                     default: state_d = S_BW_FILL;
                  endcase
               end
            end
         end
         S_RD_REQ: begin
            if (bus.ready_i) begin
               req_d    = 1'b1;
               rw_d     = 1'b0;
               reqdev_d = dev_q;
               state_d  = S_RD_WAIT;
            end
         end
         S_RD_WAIT: begin
            if (bus.done_i) begin
               rd_d    = bus.data_i;
               clear_d = 1'b1;
               state_d = S_RD_PUSH;
            end
         end
         S_RD_PUSH: begin
            if (can_push) begin
               tx_write = 1'b1;
               tx_data  = rd_q;
               csum_d   = csum_q ^ rd_q;
               add_d    = add_q + ADD_WORD;
               n_d      = n_q - 16'd1;
               state_d  = (n_q == 16'd1) ? S_CSUM_TX : S_RD_REQ;
            end
         end
         S_WR_POP: begin
            if (can_pop) begin
               rx_read = 1'b1;
               data_d  = rx_word;
               csum_d  = csum_q ^ rx_word;
               state_d = S_WR_REQ;
            end
         end
         S_WR_REQ: begin
            if (bus.ready_i) begin
               req_d    = 1'b1;
               rw_d     = 1'b1;
               reqdev_d = dev_q;
               state_d  = S_WR_WAIT;
            end
         end
         S_WR_WAIT: begin
            if (bus.done_i) begin
               clear_d = 1'b1;
               add_d   = add_q + ADD_WORD;
               n_d     = n_q - 16'd1;
               state_d = (n_q == 16'd1) ? S_CSUM_RX : S_WR_POP;
            end
         end
         S_BR_REQ: begin
            if (bus.ready_i) begin
               req_d       = 1'b1;
               req_block_d = 1'b1;
               rw_d        = 1'b0;
               reqdev_d    = dev_q;
               wp_d        = '0;
               rp_d        = '0;
               done_seen_d = 1'b0;
               state_d     = S_BR_XFER;
            end
         end
         S_BR_XFER: begin
            // Stores land before the drain and completion tests, so a word arriving with
            // done_i is still forwarded; the burst closes only once every word is pushed.
            if (bus.valid_i && wp_q != PTR_FULL) begin
               buf_d[wp_q[IDX_W-1:0]] = bus.data_i;
               wp_d = wp_q + 1'b1;
            end
            if (rp_q < wp_q && can_push) begin
               tx_write = 1'b1;
               tx_data  = buf_q[rp_q[IDX_W-1:0]];
               csum_d   = csum_q ^ buf_q[rp_q[IDX_W-1:0]];
               rp_d     = rp_nxt;
            end
            if (bus.done_i) begin
               clear_d     = 1'b1;
               done_seen_d = 1'b1;
            end
            if (done_seen_q && rp_q == PTR_FULL) begin
               req_block_d = 1'b0;
               done_seen_d = 1'b0;
               add_d       = add_q + ADD_BURST;
               n_d         = n_q - N_BURST;
               wp_d        = '0;
               rp_d        = '0;
               state_d     = (n_q == N_BURST) ? S_CSUM_TX : S_BR_REQ;
            end
         end
         S_BW_FILL: begin
            if (can_pop) begin
               rx_read                = 1'b1;
               buf_d[wp_q[IDX_W-1:0]] = rx_word;
               csum_d                 = csum_q ^ rx_word;
               wp_d                   = wp_q + 1'b1;
               if (wp_q == PTR_FULL - 1'b1) state_d = S_BW_REQ;
            end
         end
         S_BW_REQ: begin
            if (bus.ready_i) begin
               req_d       = 1'b1;
               req_block_d = 1'b1;
               rw_d        = 1'b1;
               reqdev_d    = dev_q;
               rp_d        = '0;
               data_d      = buf_q[0];
               state_d     = S_BW_XFER;
            end
         end
         S_BW_XFER: begin
            if (bus.valid_i) begin
               rp_d   = rp_nxt;
               data_d = buf_q[rp_nxt[IDX_W-1:0]];
            end
            if (bus.done_i) begin
               clear_d     = 1'b1;
               req_block_d = 1'b0;
               add_d       = add_q + ADD_BURST;
               n_d         = n_q - N_BURST;
               wp_d        = '0;
               rp_d        = '0;
               state_d     = (n_q == N_BURST) ? S_CSUM_RX : S_BW_FILL;
            end
         end
         S_CSUM_TX: begin
            if (can_push) begin
               tx_write = 1'b1;
               tx_data  = csum_q;
               state_d  = S_IDLE;
            end
         end
         S_CSUM_RX: begin
            if (can_pop) begin
               rx_read = 1'b1;
               if (rx_word == csum_q) begin
                  state_d = S_ACK;
               end else begin
                  err_d   = 3'd3;
                  state_d = S_ERR;
               end
            end
         end
         S_ACK: begin
            if (can_push) begin
               tx_write = 1'b1;
               tx_data  = '0;
               state_d  = S_IDLE;
            end
         end
         S_ERR: begin
            if (can_push) begin
               tx_write = 1'b1;
               tx_data  = {4'hE, 25'd0, err_q};
               exc_d    = 1'b1;
               state_d  = S_SYNC;
            end
         end
         default: begin
            cnt_d   = CNT_PURGE;
            state_d = S_PURGE;
         end
      endcase
   end

   always_ff @(posedge clock_i or negedge resetn_i) begin
      if (!resetn_i) begin
         state_q     <= S_PURGE;
         cnt_q       <= CNT_PURGE;
         op_q        <= '0;
         dev_q       <= '0;
         blk_q       <= 1'b0;
         n_q         <= '0;
         csum_q      <= '0;
         rd_q        <= '0;
         wp_q        <= '0;
         rp_q        <= '0;
         done_seen_q <= 1'b0;
         err_q       <= '0;
         req_q       <= 1'b0;
         req_block_q <= 1'b0;
         rw_q        <= 1'b0;
         reqdev_q    <= '0;
         add_q       <= '0;
         data_q      <= '0;
         clear_q     <= 1'b0;
         exc_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         op_q        <= op_d;
         dev_q       <= dev_d;
         blk_q       <= blk_d;
         n_q         <= n_d;
         csum_q      <= csum_d;
         rd_q        <= rd_d;
         wp_q        <= wp_d;
         rp_q        <= rp_d;
         done_seen_q <= done_seen_d;
         err_q       <= err_d;
         req_q       <= req_d;
         req_block_q <= req_block_d;
         rw_q        <= rw_d;
         reqdev_q    <= reqdev_d;
         add_q       <= add_d;
         data_q      <= data_d;
         clear_q     <= clear_d;
         exc_q       <= exc_d;
      end
   end

   // Burst buffer contents are always qualified by the pointers, so they carry no reset.
   always_ff @(posedge clock_i) begin
      buf_q <= buf_d;
   end

   assign bus.rx_read_o   = rx_read;
   assign bus.tx_write_o  = tx_write;
   assign bus.tx_data_o   = tx_data;
   assign bus.req_o       = req_q;
   assign bus.req_block_o = req_block_q;
   assign bus.rw_o        = rw_q;
   assign bus.reqdev_o    = reqdev_q;
   assign bus.add_o       = add_q;
   assign bus.data_o      = data_q;
   assign bus.clear_o     = clear_q;
   assign bus.exception_o = exc_q;

endmodule

// File: tb/tb_comm_controller_v3.sv
// Scoreboard bench for comm_controller_v3: FIFO and bus models in one sampling loop,
// expected tx words and bus requests queued when stimulus is issued.
module tb_comm_controller_v3;

   localparam int unsigned ADDR_W = 27;
   localparam int unsigned DEV_W  = 3;
   localparam int unsigned BL     = 16;
   localparam int unsigned PURGE  = 64;
   localparam logic [31:0] KEY    = 32'h4A78B9F2;
   localparam logic [31:0] XS     = 32'hCD0031F7;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic        rw;
      logic        blk;
      logic [2:0]  dev;
      logic        chk_addr;
      logic        chk_data;
   } req_t;

   logic clock_i  = 1'b0;
   logic resetn_i = 1'b0;
   always #5 clock_i = ~clock_i;

   comm_controller_v3_if #(.ADDR_W(ADDR_W), .DEV_W(DEV_W)) bus_if ();

   comm_controller_v3 #(
      .ADDR_W(ADDR_W), .DEV_W(DEV_W), .BURST_LEN(BL), .PURGE_CYCLES(PURGE),
      .KEY_SYNC(KEY), .XOR_SYNC(XS)
   ) dut (
      .clock_i (clock_i),
      .resetn_i(resetn_i),
      .bus     (bus_if.master)
   );

   int          err_cnt = 0;
   int          chk_cnt = 0;
   logic [31:0] rx_fifo [$];
   logic [31:0] exp_tx  [$];
   logic [31:0] exp_bw  [$];
   req_t        exp_req [$];
   int          bus_st  = 0;
   int          bus_cnt = 0;
   int          bus_beat = 0;
   logic [31:0] bus_base = '0;
   logic        done_prev = 1'b0;
   bit          tx_toggle = 1'b0;
   int          tog_cnt = 0;
   int          n_req = 0;
   int          n_clr = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %08h want %08h", tag, act, exp);
      end
   endtask

   function automatic logic [31:0] rd_data(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   task automatic rx(input logic [31:0] w);
      rx_fifo.push_back(w);
   endtask

   task automatic exp_r(input logic rw, input logic blk, input logic [2:0] dev,
                        input logic [31:0] addr, input logic [31:0] data,
                        input logic ca, input logic cd);
      req_t e;
      e.addr = addr; e.data = data; e.rw = rw; e.blk = blk; e.dev = dev;
      e.chk_addr = ca; e.chk_data = cd;
      exp_req.push_back(e);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_ctl"}, {25'd0, bus_if.rx_read_o, bus_if.tx_write_o, bus_if.req_o,
           bus_if.req_block_o, bus_if.rw_o, bus_if.clear_o, bus_if.exception_o}, 32'd0);
      chk({tag, "_txd"}, bus_if.tx_data_o, 32'd0);
      chk({tag, "_add"}, 32'(bus_if.add_o), 32'd0);
      chk({tag, "_dat"}, {bus_if.data_o[31:3], bus_if.data_o[2:0] | bus_if.reqdev_o}, 32'd0);
   endtask

   task automatic drain(input string tag, input int budget);
      int n = 0;
      while ((rx_fifo.size() != 0 || exp_tx.size() != 0 || exp_req.size() != 0 ||
              exp_bw.size() != 0 || bus_st != 0) && n < budget) begin
         @(negedge clock_i);
         n++;
      end
      repeat (6) @(negedge clock_i);
      chk(tag, 32'(rx_fifo.size() + exp_tx.size() + exp_req.size() + exp_bw.size()), 32'd0);
   endtask

   // FIFO and bus environment: drive at negedge, sample 4 ns later (before the posedge)
   initial begin
      bit          bw_beat;
      logic [31:0] dummy;
      req_t        e;
      bus_if.rx_empty_i = 1'b1;
      bus_if.rx_data_i  = '0;
      bus_if.tx_full_i  = 1'b0;
      bus_if.ready_i    = 1'b0;
      bus_if.done_i     = 1'b0;
      bus_if.valid_i    = 1'b0;
      bus_if.data_i     = '0;
      forever begin
         @(negedge clock_i);
         bus_if.rx_empty_i = (rx_fifo.size() == 0);
         bus_if.rx_data_i  = (rx_fifo.size() == 0) ? 32'd0 : rx_fifo[0];
         if (tx_toggle) begin
            tog_cnt++;
            if (tog_cnt == 3) begin
               tog_cnt = 0;
               bus_if.tx_full_i = ~bus_if.tx_full_i;
            end
         end else begin
            bus_if.tx_full_i = 1'b0;
         end
         bus_if.ready_i = 1'b0;
         bus_if.done_i  = 1'b0;
         bus_if.valid_i = 1'b0;
         bw_beat = 1'b0;
         case (bus_st)
            0: bus_if.ready_i = ($urandom_range(0, 3) != 0);
            1, 2: begin
               if (bus_cnt > 0) bus_cnt--;
               else begin
                  bus_if.done_i = 1'b1;
                  bus_if.data_i = rd_data(bus_base);
                  bus_st = 0;
               end
            end
            3, 4: begin
               if ($urandom_range(0, 3) != 0) begin
                  bus_if.valid_i = 1'b1;
                  bus_if.data_i  = rd_data(bus_base + 32'(4 * bus_beat));
                  bw_beat = (bus_st == 4);
                  bus_beat++;
                  if (bus_beat == BL) begin
                     bus_if.done_i = 1'b1;
                     bus_st = 0;
                  end
               end
            end
            default: bus_st = 0;
         endcase
         #4;
         if (bus_if.rx_read_o && rx_fifo.size() > 0) dummy = rx_fifo.pop_front();
         if (bus_if.tx_write_o) begin
            if (exp_tx.size() > 0) chk("tx", bus_if.tx_data_o, exp_tx.pop_front());
            else chk("tx_unexp", {31'd0, bus_if.tx_write_o}, 32'd0);
         end
         if (bw_beat) begin
            if (exp_bw.size() > 0) chk("bw_data", bus_if.data_o, exp_bw.pop_front());
            else chk("bw_unexp", {31'd0, bw_beat}, 32'd0);
         end
         if (bus_if.clear_o || done_prev) chk("clear", {31'd0, bus_if.clear_o}, {31'd0, done_prev});
         if (bus_if.clear_o) n_clr++;
         done_prev = bus_if.done_i;
         if (bus_if.req_o) begin
            n_req++;
            if (exp_req.size() > 0) begin
               e = exp_req.pop_front();
               chk("req_ctl", {27'd0, bus_if.rw_o, bus_if.req_block_o, bus_if.reqdev_o},
                   {27'd0, e.rw, e.blk, e.dev});
               if (e.chk_addr) chk("req_add", 32'(bus_if.add_o), e.addr);
               if (e.chk_data) chk("req_dat", bus_if.data_o, e.data);
            end else begin
               chk("req_unexp", {31'd0, bus_if.req_o}, 32'd0);
            end
            bus_base = 32'(bus_if.add_o);
            bus_beat = 0;
            bus_cnt  = $urandom_range(0, 3);
            if (bus_if.req_block_o) bus_st = bus_if.rw_o ? 4 : 3;
            else                    bus_st = bus_if.rw_o ? 2 : 1;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] cs;
      logic [31:0] w;
      int          r0, c0;

      repeat (2) @(posedge clock_i);
      #1;
      chk_zero("rst");
      @(negedge clock_i);
      resetn_i = 1'b1;

      // 1: purge, echo in SYNC, then key
      repeat (PURGE + 10) @(negedge clock_i);
      rx(32'h1); exp_tx.push_back(32'hCD0031F6);
      rx(KEY);
      drain("t1_drain", 300);
      chk("t1_exc", {31'd0, bus_if.exception_o}, 32'd0);

      // 2: single read of two words
      rx(32'h0); rx(32'h0000_0002); rx(32'h100);
      exp_r(1'b0, 1'b0, 3'd0, 32'h100, 32'h0, 1'b1, 1'b0);
      exp_r(1'b0, 1'b0, 3'd0, 32'h104, 32'h0, 1'b1, 1'b0);
      exp_tx.push_back(rd_data(32'h100));
      exp_tx.push_back(rd_data(32'h104));
      exp_tx.push_back(rd_data(32'h100) ^ rd_data(32'h104));
      drain("t2_drain", 300);

      // 3: single write with good then bad checksum
      for (int pass = 0; pass < 2; pass++) begin
         rx(32'h0); rx(32'h4000_0003); rx(32'h200);
         rx(32'h1); rx(32'h2); rx(32'h4);
         rx(pass == 0 ? 32'h7 : 32'h6);
         exp_r(1'b1, 1'b0, 3'd0, 32'h200, 32'h1, 1'b1, 1'b1);
         exp_r(1'b1, 1'b0, 3'd0, 32'h204, 32'h2, 1'b1, 1'b1);
         exp_r(1'b1, 1'b0, 3'd0, 32'h208, 32'h4, 1'b1, 1'b1);
         exp_tx.push_back(pass == 0 ? 32'h0 : 32'hE000_0003);
         drain("t3_drain", 400);
         chk("t3_exc", {31'd0, bus_if.exception_o}, pass == 0 ? 32'd0 : 32'd1);
      end
      rx(KEY);

      // config to device 1
      rx(32'h0); rx(32'h8800_1234);
      exp_r(1'b1, 1'b0, 3'd1, 32'h0, 32'h0000_1234, 1'b0, 1'b1);
      exp_tx.push_back(32'h0);
      drain("cfg_drain", 300);

      // zero word count, then misaligned block address
      rx(32'h0); rx(32'h0000_0000);
      exp_tx.push_back(32'hE000_0002);
      rx(KEY);
      rx(32'h0); rx(32'h4400_0010); rx(32'h404);
      exp_tx.push_back(32'hE000_0004);
      rx(KEY);
      drain("err_drain", 300);

      // block write of one burst to device 1
      rx(32'h0); rx(32'h4C00_0010); rx(32'h800);
      cs = '0;
      for (int i = 0; i < int'(BL); i++) begin
         w = 32'h1000_0000 + 32'(i * 32'h11);
         rx(w); exp_bw.push_back(w); cs ^= w;
      end
      rx(cs);
      exp_r(1'b1, 1'b1, 3'd1, 32'h800, 32'h1000_0000, 1'b1, 1'b1);
      exp_tx.push_back(32'h0);
      drain("bw_drain", 600);

      // 4: block read of two bursts with tx back-pressure
      r0 = n_req; c0 = n_clr;
      tx_toggle = 1'b1;
      rx(32'h0); rx(32'h0400_0000 | 32'(2 * BL)); rx(32'h400);
      exp_r(1'b0, 1'b1, 3'd0, 32'h400, 32'h0, 1'b1, 1'b0);
      exp_r(1'b0, 1'b1, 3'd0, 32'h400 + 32'(4 * BL), 32'h0, 1'b1, 1'b0);
      cs = '0;
      for (int i = 0; i < int'(2 * BL); i++) begin
         w = rd_data(32'h400 + 32'(4 * i));
         exp_tx.push_back(w); cs ^= w;
      end
      exp_tx.push_back(cs);
      drain("t4_drain", 1000);
      tx_toggle = 1'b0;
      chk("t4_nreq", 32'(n_req - r0), 32'd2);
      chk("t4_nclr", 32'(n_clr - c0), 32'd2);

      // 5: bad header, resync, then a read to device 2
      rx(32'h5); exp_tx.push_back(32'hE000_0001);
      rx(KEY);
      rx(32'h0); rx(32'h1000_0001); rx(32'h300);
      exp_r(1'b0, 1'b0, 3'd2, 32'h300, 32'h0, 1'b1, 1'b0);
      exp_tx.push_back(rd_data(32'h300));
      exp_tx.push_back(rd_data(32'h300));
      drain("t5_drain", 400);

      // 6: reset while filling a block write
      rx(32'h0); rx(32'h4400_0010); rx(32'h900);
      for (int i = 0; i < 5; i++) rx(32'hA000_0000 + 32'(i));
      begin
         int n = 0;
         while (rx_fifo.size() != 0 && n < 200) begin
            @(negedge clock_i);
            n++;
         end
         chk("t6_fill", 32'(rx_fifo.size()), 32'd0);
      end
      repeat (3) @(negedge clock_i);
      resetn_i = 1'b0;
      @(posedge clock_i);
      #1;
      chk_zero("t6");
      @(negedge clock_i);
      resetn_i = 1'b1;
      rx(32'h1234_5678);
      repeat (PURGE + 20) @(negedge clock_i);
      rx(32'h2); exp_tx.push_back(32'hCD0031F5);
      rx(KEY);
      drain("t6_drain", 300);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
